// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default line/clock constants,
// kept here so the transmitter can reuse them.
package uart_pkg;

    localparam int UART_CLK_FREQ = 50_000_000;
    localparam int UART_BAUD     = 9600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RST_VAL sets the value both flops take while reset is held.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a baud counter, single-entry output
// register with valid/ready handshake, frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = UART_CLK_FREQ,
    parameter int BAUD     = UART_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    logic              w_rx_s;
    uart_state_e       r_state;
    logic              r_rx_prev;
    logic [CNT_W-1:0]  r_baud_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic              r_frame_err;
    logic              r_overrun;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rx_prev   <= 1'b1;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_prev   <= w_rx_s;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            // A completing byte below overrides this clear, so a same-cycle
            // handshake hands over the old byte and keeps valid for the new one.
            if (r_rx_valid && rx_ready)
                r_rx_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_state    <= ST_START;
                        r_baud_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (r_baud_cnt == HALF_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_baud_cnt == FULL_LAST) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= ST_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_baud_cnt == FULL_LAST) begin
                        r_baud_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                            if (!r_rx_valid || rx_ready) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun  <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    // Leaving only on a high line means a break can't fake a start edge.
                    if (w_rx_s)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled-down baud divider (16 clocks/bit)
// so every scenario fits in a short run.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int B        = 16;   // CLK_FREQ / BAUD
    localparam int H        = 8;    // B / 2
    // Two synchronizer edges before the detect cycle, then 1 + H + 9*B.
    localparam int LAT      = 2 + 1 + H + 9 * B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int cyc = 0, start_cyc = 0, rise_cyc = 0;
    int vld_rises = 0, vld_hi = 0, ferr_n = 0, ovr_n = 0;
    int n_chk = 0, n_pass = 0;
    logic prev_v = 1'b0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_v) begin
            vld_rises = vld_rises + 1;
            rise_cyc  = cyc;
        end
        if (rx_valid)  vld_hi = vld_hi + 1;
        if (frame_err) ferr_n = ferr_n + 1;
        if (overrun)   ovr_n  = ovr_n + 1;
        prev_v = rx_valid;
    end

    // Leaves rx at the stop-bit level so callers can hold a break afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1;
        rx = 1'b0;
        start_cyc = cyc;
        repeat (B) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(posedge clk); #1;
        end
        rx = stop_bit;
        repeat (B) @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_chk++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else n_pass++;
        n_chk++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else n_pass++;
        n_chk++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_glitch;
        int r0, f0;
        r0 = vld_rises; f0 = ferr_n;
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (4) @(posedge clk); #1;
        rx = 1'b1;
        repeat (2 * B) @(posedge clk); #1;
        n_chk++; if (vld_rises - r0 !== 0) $display("FAIL glitch_valid: got %0d pulses want 0", vld_rises - r0); else n_pass++;
        n_chk++; if (ferr_n - f0 !== 0) $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_n - f0); else n_pass++;
        n_chk++; if (dut.r_state !== ST_IDLE) $display("FAIL glitch_state: got %0d want %0d", dut.r_state, ST_IDLE); else n_pass++;
    endtask

    task automatic test_byte_a5;
        int r0, h0, f0;
        r0 = vld_rises; h0 = vld_hi; f0 = ferr_n;
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(posedge clk); #1;
        n_chk++; if (vld_rises - r0 !== 1) $display("FAIL a5_pulses: got %0d want 1", vld_rises - r0); else n_pass++;
        n_chk++; if (vld_hi - h0 !== 1) $display("FAIL a5_width: got %0d cycles want 1", vld_hi - h0); else n_pass++;
        n_chk++; if (rx_data !== 8'hA5) $display("FAIL a5_data: got %h want a5", rx_data); else n_pass++;
        n_chk++; if (rise_cyc - start_cyc !== LAT) $display("FAIL a5_latency: got %0d want %0d", rise_cyc - start_cyc, LAT); else n_pass++;
        n_chk++; if (ferr_n - f0 !== 0) $display("FAIL a5_ferr: got %0d want 0", ferr_n - f0); else n_pass++;
    endtask

    task automatic test_frame_err;
        int r0, f0;
        r0 = vld_rises; f0 = ferr_n;
        send_frame(8'h3C, 1'b0);
        repeat (3 * B) @(posedge clk); #1;
        n_chk++; if (ferr_n - f0 !== 1) $display("FAIL ferr_pulses: got %0d want 1", ferr_n - f0); else n_pass++;
        n_chk++; if (vld_rises - r0 !== 0) $display("FAIL ferr_valid: got %0d want 0", vld_rises - r0); else n_pass++;
        n_chk++; if (dut.r_state !== ST_WAIT_IDLE) $display("FAIL ferr_break_state: got %0d want %0d", dut.r_state, ST_WAIT_IDLE); else n_pass++;
        rx = 1'b1;
        repeat (B) @(posedge clk); #1;
        n_chk++; if (dut.r_state !== ST_IDLE) $display("FAIL ferr_recover_state: got %0d want %0d", dut.r_state, ST_IDLE); else n_pass++;
        send_frame(8'h81, 1'b1);
        repeat (2) @(posedge clk); #1;
        n_chk++; if (rx_data !== 8'h81) $display("FAIL ferr_next_data: got %h want 81", rx_data); else n_pass++;
    endtask

    task automatic test_overrun;
        int o0;
        o0 = ovr_n;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2) @(posedge clk); #1;
        n_chk++; if (ovr_n - o0 !== 1) $display("FAIL ovr_pulses: got %0d want 1", ovr_n - o0); else n_pass++;
        n_chk++; if (rx_data !== 8'h11) $display("FAIL ovr_data: got %h want 11", rx_data); else n_pass++;
        n_chk++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", rx_valid); else n_pass++;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        n_chk++; if (rx_valid !== 1'b0) $display("FAIL ovr_consume: got %b want 0", rx_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int o0;
        o0 = ovr_n;
        rx_ready = 1'b0;
        send_frame(8'h55, 1'b1);
        n_chk++; if (rx_data !== 8'h55) $display("FAIL b2b_first_data: got %h want 55", rx_data); else n_pass++;
        fork
            send_frame(8'h66, 1'b1);
            begin
                // Ready is high only during the cycle the 0x66 stop bit is sampled.
                @(posedge clk);
                repeat (2 + H + 9 * B) @(posedge clk); #1;
                rx_ready = 1'b1;
                @(posedge clk); #1;
                rx_ready = 1'b0;
            end
        join
        repeat (2) @(posedge clk); #1;
        n_chk++; if (rx_data !== 8'h66) $display("FAIL b2b_data: got %h want 66", rx_data); else n_pass++;
        n_chk++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", rx_valid); else n_pass++;
        n_chk++; if (ovr_n - o0 !== 0) $display("FAIL b2b_ovr: got %0d want 0", ovr_n - o0); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        int r0;
        r0 = vld_rises;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                @(posedge clk);
                repeat (5 * B + H) @(posedge clk); #3;
                rst_n = 1'b0;
                #1;
                n_chk++; if (rx_data !== 8'h00) $display("FAIL midrst_data: got %h want 00", rx_data); else n_pass++;
                n_chk++; if (rx_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", rx_valid); else n_pass++;
                n_chk++; if ({frame_err, overrun} !== 2'b00) $display("FAIL midrst_pulses: got %b want 00", {frame_err, overrun}); else n_pass++;
                repeat (3) @(posedge clk); #1;
                rst_n = 1'b1;
            end
        join
        repeat (B) @(posedge clk); #1;
        n_chk++; if (vld_rises - r0 !== 0) $display("FAIL midrst_no_output: got %0d want 0", vld_rises - r0); else n_pass++;
        rx_ready = 1'b1;
        send_frame(8'h0F, 1'b1);
        repeat (2) @(posedge clk); #1;
        n_chk++; if (rx_data !== 8'h0F) $display("FAIL midrst_next_data: got %h want 0f", rx_data); else n_pass++;
        n_chk++; if (vld_rises - r0 !== 1) $display("FAIL midrst_next_pulses: got %0d want 1", vld_rises - r0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_byte_a5();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning the line bit rate; BAUD_DIV = CLK_FREQ/BAUD (5208 at defaults), HALF_DIV = BAUD_DIV/2 (2604).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: the serial line, asynchronous to clk, idle high.
REQ-006 The block SHALL have port rx_data, output, 8 bits: the last received byte.
REQ-007 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-008 The block SHALL have port rx_ready, input, 1 bit: the consumer accepts rx_data in a cycle where rx_valid and rx_ready are both high.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-011 The block SHALL pass rx through a 2-flop synchronizer reset to 1; only the synchronized value rx_s is used.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE, plus a bit counter (0..7) and a baud counter sized for BAUD_DIV-1.
REQ-013 In IDLE, a falling edge of rx_s (previous 1, current 0) SHALL enter START with the baud counter cleared.
REQ-014 START SHALL sample rx_s when the baud counter reaches HALF_DIV-1; a high sample returns to IDLE (false start, no output), and a low sample enters DATA with both counters cleared.
REQ-015 DATA SHALL sample rx_s each time the baud counter reaches BAUD_DIV-1, shifting bits in LSB first, and SHALL enter STOP after the 8th sample.
REQ-016 STOP SHALL sample rx_s when the baud counter reaches BAUD_DIV-1; a high sample completes the byte and enters IDLE.
REQ-017 In STOP, a low stop sample SHALL pulse frame_err for one cycle, discard the byte, leave rx_valid and rx_data unchanged, and enter WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL stay until rx_s is high, then enter IDLE; a break therefore never creates a spurious start.
REQ-019 On byte completion with rx_valid low, the block SHALL load rx_data and set rx_valid on the next clk edge.
REQ-020 rx_valid SHALL stay high with rx_data stable until a handshake cycle, after which it clears on the next edge.
REQ-021 On byte completion with rx_valid high and rx_ready low, the block SHALL keep the old rx_data, drop the new byte, and pulse overrun for one cycle.
REQ-022 On byte completion in the same cycle as a handshake, the block SHALL load the new byte, keep rx_valid high, and not pulse overrun.
REQ-023 Latency SHALL be fixed: rx_valid rises 1 + HALF_DIV + 9*BAUD_DIV cycles after the cycle in which the falling edge is detected in IDLE.

Reset
REQ-024 While rst_n is low, the block SHALL immediately set the FSM to IDLE, all counters and the shift register to 0, synchronizer flops to 1, rx_data to 8'h00, and rx_valid, frame_err and overrun to 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no output; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-026 The state enumeration and the default CLK_FREQ/BAUD constants SHALL live in the shared package uart_pkg, for reuse by the transmitter.
REQ-027 The synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value parameter set to 1); everything else stays in uart_rx.

Verification
REQ-028 With defaults, a low glitch of 5000 ns on rx SHALL produce no rx_valid and no frame_err, and the FSM SHALL return to IDLE.
REQ-029 Sending 0xA5 at 9600 baud with rx_ready=1 SHALL set rx_valid for exactly 1 cycle with rx_data=8'hA5, at the latency given in REQ-023.
REQ-030 A frame of 0x3C whose stop bit is low SHALL pulse frame_err once, leave rx_valid low, and accept no new start until rx returns high.
REQ-031 Sending 0x11 then 0x22 with rx_ready=0 SHALL pulse overrun once, keep rx_data=8'h11, and leave rx_valid high.
REQ-032 Sending 0x55 with rx_ready pulsed high exactly in the completion cycle of a second byte 0x66 SHALL end with rx_data=8'h66, rx_valid=1 and no overrun.
REQ-033 Asserting rst_n low during bit 4 of 0xF0 SHALL clear all outputs; the following 0x0F frame SHALL then be received correctly.
